// File: rtl/spi_wb_burst_bridge_pkg.sv
// Shared definitions for the SPI-to-Wishbone burst bridge: FSM states, host vector
// field offsets and readback status bit positions.
package spi_wb_burst_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // host vector (spi_out), LSB upwards: cpu_rst, sys_rst, start, we, sel, idx, len, wdat, adr
    localparam int B_CPU_RST = 0;
    localparam int B_SYS_RST = 1;
    localparam int B_START   = 2;
    localparam int B_WE      = 3;
    localparam int F_SEL     = 4;

    // readback status byte
    localparam int S_CPU_RST = 0;
    localparam int S_SYS_RST = 1;
    localparam int S_BUSY    = 2;
    localparam int S_DONE    = 3;
    localparam int S_REJ     = 4;
    localparam int S_ERR     = 5;

    function automatic int off_idx(input int sw);
        return F_SEL + sw;
    endfunction

    function automatic int off_len(input int sw, input int lw);
        return F_SEL + sw + lw;
    endfunction

    function automatic int off_wdat(input int sw, input int lw);
        return F_SEL + sw + 2*lw;
    endfunction

    function automatic int off_adr(input int sw, input int lw, input int dw);
        return off_wdat(sw, lw) + dw;
    endfunction

endpackage

// File: rtl/spi_wb_burst_fsm.sv
// Burst sequencing FSM: state, beat counter, optional ack timeout and sticky flags.
// Timeout counter is present only when SPI_WB_TIMEOUT_EN is defined.
module spi_wb_burst_fsm
    import spi_wb_burst_bridge_pkg::*;
#(
    parameter int LW        = 3,
    parameter int TO_CYCLES = 1023
) (
    input  logic          clk,
    input  logic          spi_reset,
    input  logic          pulse,
    input  logic          cpu_rst,
    input  logic [LW-1:0] len,
    input  logic          ack,
    output logic          cyc,
    output logic          busy,
    output logic          accept,
    output logic          in_gap,
    output logic          beat_ack,
    output logic [LW-1:0] beats_done,
    output logic          done,
    output logic          err,
    output logic          rej
);

    state_t        state, state_nxt;
    logic [LW-1:0] len_q;
    logic          last_beat;
    logic          timeout;

    if (TO_CYCLES < 1) begin : g_bad_to_cycles
        $error("TO_CYCLES must be at least 1");
    end

`ifdef SPI_WB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    // Held at zero outside REQ, so every beat starts a fresh window.
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset)            to_cnt <= '0;
        else if (state != ST_REQ)  to_cnt <= '0;
        else if (!ack)             to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = (state == ST_REQ) && !ack && (to_cnt == TW'(TO_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Compared before the increment: beat number len is the final one.
    assign last_beat = (beats_done == len_q);

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (pulse && cpu_rst) state_nxt = ST_REQ;
            ST_REQ: begin
                if (ack)          state_nxt = (last_beat || !cpu_rst) ? ST_IDLE : ST_GAP;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_GAP:  state_nxt = cpu_rst ? ST_REQ : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cyc      = (state == ST_REQ);
        busy     = (state != ST_IDLE);
        accept   = (state == ST_IDLE) && pulse && cpu_rst;
        in_gap   = (state == ST_GAP);
        beat_ack = (state == ST_REQ) && ack;
    end

    // beats_done is LW bits wide, so a full DEPTH-beat burst reads back as 0.
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) begin
            beats_done <= '0;
            len_q      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rej        <= 1'b0;
        end else begin
            if (accept) begin
                beats_done <= '0;
                len_q      <= len;
                done       <= 1'b0;
                err        <= 1'b0;
                rej        <= 1'b0;
            end else if (state == ST_IDLE && pulse) begin
                rej <= 1'b1;
            end
            if (beat_ack) begin
                beats_done <= beats_done + 1'b1;
                if (last_beat)     done <= 1'b1;
                else if (!cpu_rst) err  <= 1'b1;
            end
            if (timeout || (in_gap && !cpu_rst)) err <= 1'b1;
        end
    end

endmodule

// File: rtl/spi_wb_burst_bridge.sv
// SPI control vector to Wishbone burst master with read buffer and reset straps.
// Optional ack timeout enabled by defining SPI_WB_TIMEOUT_EN.
module spi_wb_burst_bridge
    import spi_wb_burst_bridge_pkg::*;
#(
    parameter int  AW        = 32,
    parameter int  DW        = 32,
    parameter int  DEPTH     = 8,
    parameter int  TO_CYCLES = 1023,
    localparam int SW        = DW / 8,
    localparam int LW        = $clog2(DEPTH),
    localparam int VW        = AW + DW + 2*LW + SW + 4
) (
    input  logic             clk,
    input  logic             spi_reset,
    input  logic [VW-1:0]    spi_out,
    output logic [DW+LW+7:0] spi_in,
    output logic [AW-1:0]    o_wb_adr,
    output logic [DW-1:0]    o_wb_dat,
    output logic [SW-1:0]    o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    input  logic [DW-1:0]    i_wb_rdt,
    input  logic             i_wb_ack,
    output logic             cpu_reset,
    output logic             system_reset
);

    logic [AW-1:0] f_adr;
    logic [LW-1:0] f_len, f_idx;
    logic          f_start;
    logic          start_q, pulse;
    logic          busy, accept, in_gap, beat_ack, done, err, rej;
    logic [LW-1:0] beats_done;
    logic [AW-1:0] adr_q;
    logic [DEPTH-1:0][DW-1:0] rbuf;
    logic [7:0]    status;

    assign f_adr        = spi_out[off_adr(SW, LW, DW) +: AW];
    assign o_wb_dat     = spi_out[off_wdat(SW, LW) +: DW];
    assign f_len        = spi_out[off_len(SW, LW) +: LW];
    assign f_idx        = spi_out[off_idx(SW) +: LW];
    assign o_wb_sel     = spi_out[F_SEL +: SW];
    assign o_wb_we      = spi_out[B_WE];
    assign f_start      = spi_out[B_START];
    assign system_reset = spi_out[B_SYS_RST];
    assign cpu_reset    = spi_out[B_CPU_RST];
    assign o_wb_adr     = adr_q;

    // Only a rising edge of the host start bit launches a transaction.
    assign pulse = f_start && !start_q;

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) start_q <= 1'b0;
        else            start_q <= f_start;
    end

    spi_wb_burst_fsm #(
        .LW        (LW),
        .TO_CYCLES (TO_CYCLES)
    ) u_fsm (
        .clk        (clk),
        .spi_reset  (spi_reset),
        .pulse      (pulse),
        .cpu_rst    (cpu_reset),
        .len        (f_len),
        .ack        (i_wb_ack),
        .cyc        (o_wb_cyc),
        .busy       (busy),
        .accept     (accept),
        .in_gap     (in_gap),
        .beat_ack   (beat_ack),
        .beats_done (beats_done),
        .done       (done),
        .err        (err),
        .rej        (rej)
    );

    // Address advances during the idle gap so the next beat presents it from its first cycle.
    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset)  adr_q <= '0;
        else if (accept) adr_q <= f_adr;
        else if (in_gap) adr_q <= adr_q + AW'(SW);
    end

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset)                rbuf <= '0;
        else if (beat_ack && !o_wb_we) rbuf[beats_done] <= i_wb_rdt;
    end

    always_comb begin
        status            = '0;
        status[S_CPU_RST] = cpu_reset;
        status[S_SYS_RST] = system_reset;
        status[S_BUSY]    = busy;
        status[S_DONE]    = done;
        status[S_REJ]     = rej;
        status[S_ERR]     = err;
    end

    always_ff @(posedge clk or negedge spi_reset) begin
        if (!spi_reset) spi_in <= '0;
        else            spi_in <= {rbuf[f_idx], beats_done, status};
    end

endmodule

// File: tb/tb_spi_wb_burst_bridge.sv
// Directed + randomized bench for spi_wb_burst_bridge against a transaction-level model.
// Honours SPI_WB_TIMEOUT_EN for the timeout scenario.
module tb_spi_wb_burst_bridge;

    localparam int AW = 32, DW = 32, DEPTH = 8, TO_CYCLES = 15;
    localparam int SW = DW / 8, LW = $clog2(DEPTH);
    localparam int VW = AW + DW + 2*LW + SW + 4, RW = DW + LW + 8;

    logic          clk = 1'b0;
    logic          spi_reset = 1'b0;
    logic [VW-1:0] spi_out;
    logic [RW-1:0] spi_in;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic          o_wb_we, o_wb_cyc, cpu_reset, system_reset;
    logic [DW-1:0] i_wb_rdt = '0;
    logic          i_wb_ack = 1'b0;

    logic [AW-1:0] f_adr = '0;
    logic [DW-1:0] f_wdat = '0;
    logic [LW-1:0] f_len = '0, f_idx = '0;
    logic [SW-1:0] f_sel = '0;
    logic          f_we = 1'b0, f_start = 1'b0, f_sys = 1'b0, f_cpu = 1'b0;

    // reference model state
    logic [DW-1:0] mbuf [DEPTH];
    bit            m_err, m_rej, m_done;
    logic [LW-1:0] m_beats;

    int checks = 0, errors = 0;

    assign spi_out = {f_adr, f_wdat, f_len, f_idx, f_sel, f_we, f_start, f_sys, f_cpu};

    always #5 clk = ~clk;

    spi_wb_burst_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TO_CYCLES(TO_CYCLES)) dut (
        .clk          (clk),
        .spi_reset    (spi_reset),
        .spi_out      (spi_out),
        .spi_in       (spi_in),
        .o_wb_adr     (o_wb_adr),
        .o_wb_dat     (o_wb_dat),
        .o_wb_sel     (o_wb_sel),
        .o_wb_we      (o_wb_we),
        .o_wb_cyc     (o_wb_cyc),
        .i_wb_rdt     (i_wb_rdt),
        .i_wb_ack     (i_wb_ack),
        .cpu_reset    (cpu_reset),
        .system_reset (system_reset)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {2'b00, m_err, m_rej, m_done, 1'b0, f_sys, f_cpu};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_status"}, spi_in[7:0], exp_status());
        chk({tag, "_beats"}, spi_in[LW+7:8], m_beats);
        chk({tag, "_cyc"}, o_wb_cyc, 1'b0);
        chk({tag, "_cpu_reset"}, cpu_reset, f_cpu);
        chk({tag, "_sys_reset"}, system_reset, f_sys);
    endtask

    task automatic rd(input int idx);
        f_idx = LW'(idx);
        @(negedge clk);
        chk($sformatf("rdbk%0d", idx), spi_in[RW-1 -: DW], mbuf[idx]);
    endtask

    // One host-launched burst; the bench plays the Wishbone slave and predicts every beat.
    task automatic run_burst(input logic [AW-1:0] base, input int nb, input bit wr,
                             input logic [DW-1:0] wd, input logic [SW-1:0] sel,
                             input logic [DW-1:0] rdt_seed, input int dly,
                             input bit toggle, input int drop_at);
        logic [AW-1:0] ea;
        logic [DW-1:0] rdt;
        int d;
        bit dropped;
        dropped = 0;
        f_adr = base; f_len = LW'(nb - 1); f_we = wr; f_wdat = wd; f_sel = sel; f_cpu = 1'b1;
        f_start = 1'b1;
        @(negedge clk);
        f_adr = $urandom;  // the latched address must not follow the host vector
        m_err = 0; m_rej = 0; m_done = 0; m_beats = '0;
        for (int i = 0; i < nb; i++) begin
            if (i > 0) @(negedge clk);
            ea = base + AW'(i * SW);
            chk($sformatf("cyc_up%0d", i), o_wb_cyc, 1'b1);
            chk($sformatf("adr%0d", i), o_wb_adr, ea);
            chk($sformatf("we%0d", i), o_wb_we, wr);
            if (wr) begin
                chk($sformatf("dat%0d", i), o_wb_dat, wd);
                chk($sformatf("sel%0d", i), o_wb_sel, sel);
            end
            d = (dly < 0) ? $urandom_range(0, 3) : dly;
            for (int k = 0; k < d; k++) begin
                if (toggle) f_start = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk($sformatf("cyc_hold%0d", i), o_wb_cyc, 1'b1);
            end
            if (i == drop_at) f_cpu = 1'b0;
            rdt = (rdt_seed != '0) ? rdt_seed * DW'(i + 1) : DW'($urandom);
            i_wb_ack = 1'b1; i_wb_rdt = rdt;
            @(negedge clk);
            i_wb_ack = 1'b0; i_wb_rdt = $urandom;
            if (!wr) mbuf[i] = rdt;
            m_beats = m_beats + 1'b1;
            chk($sformatf("cyc_gap%0d", i), o_wb_cyc, 1'b0);
            if (i == drop_at) begin
                dropped = 1;
                break;
            end
        end
        if (dropped) m_err = 1;
        else         m_done = 1;
        f_start = 1'b0;
        @(negedge clk);
        check_idle("burst_end");
        repeat (3) @(negedge clk);
        chk("stay_idle", o_wb_cyc, 1'b0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mbuf[i] = '0;
        m_err = 0; m_rej = 0; m_done = 0; m_beats = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cyc", o_wb_cyc, 1'b0);
        chk("rst_adr", o_wb_adr, '0);
        chk("rst_spi_in", spi_in, '0);
        spi_reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_rst");

        // single write
        run_burst(32'h100, 1, 1'b1, 32'hDEADBEEF, 4'hF, '0, 2, 1'b0, -1);

        // four-beat read with known data, readback by idx
        run_burst(32'h200, 4, 1'b0, '0, 4'hF, 32'h11, -1, 1'b0, -1);
        rd(2);
        rd(0);
        rd(3);

        // rejected start, then accepted start clears REJ
        f_cpu = 1'b0;
        @(negedge clk);
        f_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rej_no_cyc", o_wb_cyc, 1'b0);
        end
        m_rej = 1;
        f_start = 1'b0;
        @(negedge clk);
        check_idle("rej");
        run_burst(32'h240, 2, 1'b1, 32'hA5A5_0001, 4'h3, '0, -1, 1'b0, -1);

        // unanswered beat
        f_adr = 32'h300; f_len = '0; f_we = 1'b0; f_cpu = 1'b1; f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        m_err = 0; m_rej = 0; m_done = 0; m_beats = '0;
`ifdef SPI_WB_TIMEOUT_EN
        n = 0;
        while (o_wb_cyc && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("to_cycles", n, TO_CYCLES);
        m_err = 1;
        @(negedge clk);
        check_idle("timeout");
`else
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_wb_cyc) n++;
            @(negedge clk);
        end
        chk("no_to_cyc_held", n, 40);
        i_wb_rdt = 32'hCAFE_F00D; i_wb_ack = 1'b1;
        @(negedge clk);
        i_wb_ack = 1'b0;
        mbuf[0] = 32'hCAFE_F00D; m_done = 1; m_beats = 1;
        @(negedge clk);
        check_idle("late_ack");
`endif

        // cpu_rst dropped during second beat of a read burst
        run_burst(32'h500, 4, 1'b0, '0, 4'hF, '0, -1, 1'b0, 1);
        rd(1);

        // random bursts with start toggled while busy
        for (int t = 0; t < 8; t++) begin
            f_sys = 1'($urandom_range(0, 1));
            run_burst(AW'($urandom) & ~AW'(3), $urandom_range(1, DEPTH), 1'($urandom_range(0, 1)),
                      DW'($urandom), SW'($urandom), '0, -1, 1'b1, -1);
            rd($urandom_range(0, DEPTH - 1));
        end

        // reset mid-burst
        f_adr = 32'h400; f_len = LW'(DEPTH - 1); f_we = 1'b0; f_cpu = 1'b1; f_start = 1'b1;
        @(negedge clk);
        chk("mid_cyc", o_wb_cyc, 1'b1);
        @(negedge clk);
        spi_reset = 1'b0;
        #1;
        chk("async_cyc", o_wb_cyc, 1'b0);
        chk("async_spi_in", spi_in, '0);
        chk("async_adr", o_wb_adr, '0);
        for (int i = 0; i < DEPTH; i++) mbuf[i] = '0;
        m_err = 0; m_rej = 0; m_done = 0; m_beats = '0;
        f_start = 1'b0;
        @(negedge clk);
        spi_reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("after_rst");
        rd(3);

        // address wrap across the top of the address space
        run_burst(32'hFFFF_FFFC, 2, 1'b0, '0, 4'hF, '0, -1, 1'b0, -1);
        rd(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
